// File: rtl/max7219_msg_seq.sv
// rtl/max7219_msg_seq.sv - loadable character-message sequencer feeding max7219_basemod
module max7219_msg_seq #(
    parameter int CHAR_W    = 6,
    parameter int IDX_W     = 3,
    parameter int DWELL_CNT = 50_000_000,
    parameter logic [CHAR_W*(2**IDX_W)-1:0] MSG_INIT =
        {6'd10, 6'd16, 6'd25, 6'd15, 6'd23, 6'd14, 6'd25, 6'd24}
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              iStart,
    input  logic              iStop,
    input  logic              iPause,
    input  logic              iLoop,
    input  logic [IDX_W:0]    iLen,
    input  logic              iWrEn,
    input  logic [IDX_W-1:0]  iWrAddr,
    input  logic [CHAR_W-1:0] iWrData,
    input  logic              iDone,
    output logic              oCall,
    output logic [CHAR_W-1:0] oData,
    output logic [IDX_W-1:0]  oIndex,
    output logic              oBusy,
    output logic              oFinish
);

    localparam int MAX_LEN = 2**IDX_W;
    localparam int LEN_W   = IDX_W + 1;
    // At least one bit even when DWELL_CNT=1 (counter then only ever holds 0).
    localparam int CNT_W   = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] DWELL_TOP = CNT_W'(DWELL_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALL,
        S_DWELL,
        S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CHAR_W-1:0] data_q, data_d;
    logic              call_q, call_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic [CHAR_W-1:0] buf_q [MAX_LEN];

    logic [LEN_W-1:0]  len_in;
    logic              at_last;

    // Clamp the requested length into 1..MAX_LEN and flag the final index.
    always_comb begin
        len_in = iLen;
        if (iLen == '0) begin
            len_in = LEN_W'(1);
        end else if (iLen > MAX_LEN_V) begin
            len_in = MAX_LEN_V;
        end
        at_last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    end

    // Message buffer: reloaded from MSG_INIT on reset, writable at any time.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= MSG_INIT[i*CHAR_W +: CHAR_W];
            end
        end else if (iWrEn) begin
            buf_q[iWrAddr] <= iWrData;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            call_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            call_q  <= call_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
        end
    end

    // Next-state logic; a stop in any active state overrides the normal step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        call_d  = call_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        loop_d  = loop_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                call_d = 1'b0;
                if (iStart && !iStop) begin
                    len_d   = len_in;
                    loop_d  = iLoop;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A write landing on the index being loaded is passed straight through.
                if (iWrEn && (iWrAddr == idx_q)) begin
                    data_d = iWrData;
                end else begin
                    data_d = buf_q[idx_q];
                end
                call_d  = 1'b1;
                state_d = S_CALL;
            end
            S_CALL: begin
                if (iDone) begin
                    call_d  = 1'b0;
                    cnt_d   = DWELL_TOP;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (!iPause) begin
                    if (cnt_q == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_NEXT: begin
                if (at_last) begin
                    if (loop_q) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (iStop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            call_d  = 1'b0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            data_d  = data_q;
            idx_d   = idx_q;
        end
    end

    assign oCall   = call_q;
    assign oData   = data_q;
    assign oIndex  = idx_q;
    assign oBusy   = busy_q;
    assign oFinish = fin_q;

endmodule
